cmos_capture_rgb565: RTL and testbench

Front-end capture stage for an 8-bit parallel CMOS sensor bus (OV7725 class, RGB565 output mode). It assembles byte pairs into RGB565 pixels and expands them to RGB888. It also discards the first FRAME_SKIP frames after reset while sensor settings settle. It drives the per_frame_* / per_img_* inputs of the RGB888-to-YCbCr444 stage directly and runs in the sensor pixel-clock domain.

---
 rtl/cmos_pkg.sv | 22 ++
 rtl/cmos_capture_rgb565.sv | 103 ++++++++++
 tb/tb_cmos_capture_rgb565.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS capture and display paths: RGB565 layout,
// channel expansion helpers and the default frame-skip count.
package cmos_pkg;

  localparam int unsigned FrameSkipDefault = 10;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // MSB replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic logic [7:0] rgb5_to_8(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] rgb6_to_8(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/cmos_capture_rgb565.sv
// Sensor-bus capture: assembles RGB565 byte pairs into pixels, expands them to RGB888
// and suppresses output until FRAME_SKIP frames have passed after reset.
module cmos_capture_rgb565
  import cmos_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = FrameSkipDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic [7:0] cmos_data,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue,
  output logic       frame_valid
);

  localparam int unsigned CntW = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FRAME_SKIP);

  logic            vsync_s1_q, href_s1_q;
  logic [7:0]      data_s1_q;
  logic            vsync_s2_q, href_s2_q;
  logic            byte_flag_q, byte_flag_d;
  logic [7:0]      byte0_q, byte0_d;
  rgb565_t         pix_q, pix_d;
  logic            clken_q, clken_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic            frame_valid_q, frame_valid_d;
  logic            vsync_rise;

  // vsync_s2_q doubles as the previous-S1 value for edge detection.
  assign vsync_rise = vsync_s1_q & ~vsync_s2_q;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    frame_valid_d = frame_valid_q;
    if (vsync_rise) begin
      if (frame_cnt_q == CntMax) begin
        frame_valid_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // A dangling odd byte is simply dropped when href falls: the phase clears.
  always_comb begin
    byte_flag_d = href_s1_q & ~byte_flag_q;
    byte0_d     = byte0_q;
    pix_d       = pix_q;
    clken_d     = 1'b0;
    if (href_s1_q) begin
      if (!byte_flag_q) begin
        byte0_d = data_s1_q;
      end else begin
        pix_d   = {byte0_q, data_s1_q};
        clken_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1_q    <= 1'b0;
      href_s1_q     <= 1'b0;
      data_s1_q     <= '0;
      vsync_s2_q    <= 1'b0;
      href_s2_q     <= 1'b0;
      byte_flag_q   <= 1'b0;
      byte0_q       <= '0;
      pix_q         <= '0;
      clken_q       <= 1'b0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      vsync_s1_q    <= cmos_vsync;
      href_s1_q     <= cmos_href;
      data_s1_q     <= cmos_data;
      vsync_s2_q    <= vsync_s1_q;
      href_s2_q     <= href_s1_q;
      byte_flag_q   <= byte_flag_d;
      byte0_q       <= byte0_d;
      pix_q         <= pix_d;
      clken_q       <= clken_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frame_valid      = frame_valid_q;
  assign post_frame_vsync = vsync_s2_q & frame_valid_q;
  assign post_frame_href  = href_s2_q & frame_valid_q;
  assign post_frame_clken = clken_q & frame_valid_q;
  assign post_img_red     = post_frame_href ? rgb5_to_8(pix_q.r) : 8'h00;
  assign post_img_green   = post_frame_href ? rgb6_to_8(pix_q.g) : 8'h00;
  assign post_img_blue    = post_frame_href ? rgb5_to_8(pix_q.b) : 8'h00;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Randomized bench for cmos_capture_rgb565: two instances (skip 2 and skip 0) share the
// sensor bus and are compared every cycle against a byte-stream reference model.
module tb_cmos_capture_rgb565;

  localparam int unsigned SkipA = 2;
  localparam int unsigned SkipB = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmos_vsync = 1'b0;
  logic       cmos_href = 1'b0;
  logic [7:0] cmos_data = 8'h00;

  logic       a_vs, a_hr, a_ck, a_fv;
  logic [7:0] a_r, a_g, a_b;
  logic       b_vs, b_hr, b_ck, b_fv;
  logic [7:0] b_r, b_g, b_b;

  always #5 clk = ~clk;

  cmos_capture_rgb565 #(.FRAME_SKIP(SkipA)) u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmos_vsync       (cmos_vsync),
    .cmos_href        (cmos_href),
    .cmos_data        (cmos_data),
    .post_frame_vsync (a_vs),
    .post_frame_href  (a_hr),
    .post_frame_clken (a_ck),
    .post_img_red     (a_r),
    .post_img_green   (a_g),
    .post_img_blue    (a_b),
    .frame_valid      (a_fv)
  );

  cmos_capture_rgb565 #(.FRAME_SKIP(SkipB)) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmos_vsync       (cmos_vsync),
    .cmos_href        (cmos_href),
    .cmos_data        (cmos_data),
    .post_frame_vsync (b_vs),
    .post_frame_href  (b_hr),
    .post_frame_clken (b_ck),
    .post_img_red     (b_r),
    .post_img_green   (b_g),
    .post_img_blue    (b_b),
    .frame_valid      (b_fv)
  );

  // One entry per sensor cycle: what that cycle's bytes imply two cycles later.
  typedef struct {
    bit        v;
    bit        h;
    bit        c;
    bit [15:0] pix;
    int        rises;
  } ev_t;

  ev_t        pipe0, pipe1;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_n = 0;
  bit         prev_v;
  int         rises;
  int         byte_idx;
  bit [7:0]   first;
  bit [15:0]  pix;
  int         second_cyc;
  logic [23:0] cap_q[$];
  int         cap_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [23:0] expand(input bit [15:0] p);
    int r5, g6, b5;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  function automatic logic [27:0] exp_vec(input ev_t e, input int skip);
    bit fv, ph;
    fv = (e.rises > skip);
    ph = e.h & fv;
    return {fv, e.v & fv, ph, e.c & fv, ph ? expand(e.pix) : 24'h0};
  endfunction

  task automatic model_reset();
    prev_v   = 1'b0;
    rises    = 0;
    byte_idx = 0;
    first    = 8'h00;
    pix      = 16'h0000;
    pipe0    = '{default: 0};
    pipe1    = '{default: 0};
  endtask

  task automatic step(input bit v, input bit h, input logic [7:0] d);
    ev_t e;
    cmos_vsync = v;
    cmos_href  = h;
    cmos_data  = d;
    if (v && !prev_v) rises++;
    prev_v = v;
    e.c = 1'b0;
    if (h) begin
      if (byte_idx % 2 == 1) begin
        pix        = {first, d};
        e.c        = 1'b1;
        second_cyc = cyc_n;
      end else begin
        first = d;
      end
      byte_idx++;
    end else begin
      byte_idx = 0;
    end
    e.v     = v;
    e.h     = h;
    e.pix   = pix;
    e.rises = rises;
    @(negedge clk);
    check("cycle_a", {4'h0, a_fv, a_vs, a_hr, a_ck, a_r, a_g, a_b}, {4'h0, exp_vec(pipe1, SkipA)});
    check("cycle_b", {4'h0, b_fv, b_vs, b_hr, b_ck, b_r, b_g, b_b}, {4'h0, exp_vec(pipe1, SkipB)});
    if (a_ck) begin
      cap_q.push_back({a_r, a_g, a_b});
      cap_cyc.push_back(cyc_n);
    end
    pipe1 = pipe0;
    pipe0 = e;
    cyc_n++;
  endtask

  task automatic cyc(input bit v, input bit h, input logic [7:0] d);
    @(posedge clk);
    #1;
    step(v, h, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    cmos_data  = 8'h00;
    #1;
    check("rst_a", {4'h0, a_fv, a_vs, a_hr, a_ck, a_r, a_g, a_b}, 32'h0);
    check("rst_b", {4'h0, b_fv, b_vs, b_hr, b_ck, b_r, b_g, b_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input logic [7:0] bytes[$]);
    foreach (bytes[i]) cyc(1'b0, 1'b1, bytes[i]);
    idle(3);
  endtask

  task automatic rand_line(input int n);
    logic [7:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    line(q);
  endtask

  task automatic vsync_pulse(input int w);
    for (int i = 0; i < w; i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    idle(2);
  endtask

  task automatic frame(input int nlines, input int npix);
    vsync_pulse(3);
    for (int l = 0; l < nlines; l++) rand_line(2 * npix);
    idle(2);
  endtask

  initial begin
    logic [7:0] q[$];
    int base;
    model_reset();
    reset_dut();

    // Stimulus begins mid-frame: nothing may come out before the first vsync rise.
    rand_line(6);
    rand_line(9);

    for (int f = 1; f <= 3; f++) begin
      base = cap_q.size();
      frame(4, 8);
      check($sformatf("skip_frame%0d_clkens", f), 32'(cap_q.size() - base), (f == 3) ? 32 : 0);
    end

    vsync_pulse(2);
    base = cap_q.size();
    q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'h84, 8'h10};
    line(q);
    check("colour_count", 32'(cap_q.size() - base), 32'd4);
    check("colour_red",   32'(cap_q[base]),     32'h00FF0000);
    check("colour_green", 32'(cap_q[base + 1]), 32'h0000FF00);
    check("colour_blue",  32'(cap_q[base + 2]), 32'h000000FF);
    check("colour_mixed", 32'(cap_q[base + 3]), 32'h00848284);

    base = cap_q.size();
    rand_line(5);
    check("odd_line_clkens", 32'(cap_q.size() - base), 32'd2);
    base = cap_q.size();
    q = '{8'h11, 8'h22};
    line(q);
    check("phase_restart_count", 32'(cap_q.size() - base), 32'd1);
    check("phase_restart_pix",   32'(cap_q[base]), 32'h00102410);
    check("clken_latency",       32'(cap_cyc[base] - second_cyc), 32'd2);

    // Reset mid-line while output is enabled.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    check("pre_reset_href", {31'h0, a_hr}, 32'h1);
    reset_dut();
    for (int f = 1; f <= 3; f++) begin
      base = cap_q.size();
      frame(2, 4);
      check($sformatf("post_reset_frame%0d_clkens", f), 32'(cap_q.size() - base),
            (f == 3) ? 8 : 0);
    end

    for (int f = 0; f < 4; f++) begin
      vsync_pulse($urandom_range(1, 3));
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) rand_line($urandom_range(1, 12));
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
